alu_share_arbiter: RTL and testbench

//  Shares one alu instance between NUM_REQ requesters (e.g. ball-physics and paddle/score logic).

---
 rtl/alu_share_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between NUM_REQ requesters.
// Latency: operands latched on the accept edge, the response is registered one edge later
// (rsp_valid high two cycles after req_ready was seen). Throughput is one op per 3 cycles.
// Backpressure: rsp_* held while rsp_ready=0; no request is accepted until the response leaves.
// Ports: clock/reset (async active-low); req_valid/req_ready plus packed per-requester
// opcode/operandA/operandB/shiftamt slices; rsp_valid/rsp_ready, rsp_id, rsp_result and
// flags; busy = not idle.
// Optional feature macro: ALU_ARB_OPCHK_EN adds rsp_error and zeroes illegal-opcode responses.

// Combinational ALU: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, anything else -> add.
module alu (
    input  logic [4:0]  opcode,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        is_not_equal,
    output logic        is_less_than,
    output logic        overflow
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum          = operand_a + operand_b;
    assign diff         = operand_a - operand_b;
    assign is_not_equal = (operand_a != operand_b);
    assign is_less_than = ($signed(operand_a) < $signed(operand_b));

    always_comb begin
        result   = sum;
        overflow = 1'b0;
        case (opcode)
            5'd0: begin
                result   = sum;
                overflow = (operand_a[31] == operand_b[31]) && (sum[31] != operand_a[31]);
            end
            5'd1: begin
                result   = diff;
                overflow = (operand_a[31] != operand_b[31]) && (diff[31] != operand_a[31]);
            end
            5'd2:    result = operand_a & operand_b;
            5'd3:    result = operand_a | operand_b;
            5'd4:    result = operand_a << shamt;
            5'd5:    result = $signed(operand_a) >>> shamt;
            default: result = sum;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [5*NUM_REQ-1:0]  req_opcode,
    input  logic [32*NUM_REQ-1:0] req_operandA,
    input  logic [32*NUM_REQ-1:0] req_operandB,
    input  logic [5*NUM_REQ-1:0]  req_shiftamt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_isNotEqual,
    output logic                  rsp_isLessThan,
    output logic                  rsp_overflow,
`ifdef ALU_ARB_OPCHK_EN
    output logic                  rsp_error,
`endif
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [4:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [4:0]        shamt_q;
    logic [ID_W-1:0]   id_q;

    // Round-robin pick: rotate the request vector so rr_ptr lands at bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        win_sum;
    logic [ID_W-1:0]      winner;
    logic                 any_valid;
    logic                 accept;

    always_comb begin
        dbl       = {req_valid, req_valid} >> rr_ptr;
        rot       = dbl[NUM_REQ-1:0];
        any_valid = 1'b0;
        win_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && rot[k]) begin
                any_valid = 1'b1;
                win_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
            end
        end
        if (win_sum >= (ID_W+1)'(NUM_REQ))
            win_sum = win_sum - (ID_W+1)'(NUM_REQ);
        winner = win_sum[ID_W-1:0];
    end

    // Operand mux for the winner.
    logic [4:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_shamt;

    always_comb begin
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_shamt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_op    = req_opcode[5*i +: 5];
                sel_a     = req_operandA[32*i +: 32];
                sel_b     = req_operandB[32*i +: 32];
                sel_shamt = req_shiftamt[5*i +: 5];
            end
        end
    end

    // Next state and grant. Grant is also gated by reset: state already reads
    // IDLE during reset, but nothing may be accepted until reset is released.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && reset) begin
                    req_ready  = NUM_REQ'(1) << winner;
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    assign busy = (state != IDLE);

    logic [31:0] alu_result;
    logic        alu_ne;
    logic        alu_lt;
    logic        alu_ovf;

    alu u_alu (
        .opcode       (op_q),
        .operand_a    (a_q),
        .operand_b    (b_q),
        .shamt        (shamt_q),
        .result       (alu_result),
        .is_not_equal (alu_ne),
        .is_less_than (alu_lt),
        .overflow     (alu_ovf)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shamt_q <= '0;
            id_q    <= '0;
        end else if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            shamt_q <= sel_shamt;
            id_q    <= winner;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_result     <= '0;
            rsp_isNotEqual <= 1'b0;
            rsp_isLessThan <= 1'b0;
            rsp_overflow   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            rsp_error      <= 1'b0;
`endif
            rr_ptr         <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
`ifdef ALU_ARB_OPCHK_EN
            // Opcodes above sra are flagged and carry an all-zero payload.
            if (op_q > 5'd5) begin
                rsp_error      <= 1'b1;
                rsp_result     <= '0;
                rsp_isNotEqual <= 1'b0;
                rsp_isLessThan <= 1'b0;
                rsp_overflow   <= 1'b0;
            end else begin
                rsp_error      <= 1'b0;
                rsp_result     <= alu_result;
                rsp_isNotEqual <= alu_ne;
                rsp_isLessThan <= alu_lt;
                rsp_overflow   <= alu_ovf;
            end
`else
            rsp_result     <= alu_result;
            rsp_isNotEqual <= alu_ne;
            rsp_isLessThan <= alu_lt;
            rsp_overflow   <= alu_ovf;
`endif
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            // Pointer moves only when a response completes, to the requester after the owner.
            rr_ptr    <= (rsp_id == ID_W'(NUM_REQ-1)) ? '0 : rsp_id + ID_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_opcode;
    logic [63:0] req_operandA;
    logic [63:0] req_operandB;
    logic [9:0]  req_shiftamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_isNotEqual;
    logic        rsp_isLessThan;
    logic        rsp_overflow;
    logic        busy;
`ifdef ALU_ARB_OPCHK_EN
    logic        rsp_error;
`endif

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_operandA   (req_operandA),
        .req_operandB   (req_operandB),
        .req_shiftamt   (req_shiftamt),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .rsp_isNotEqual (rsp_isNotEqual),
        .rsp_isLessThan (rsp_isLessThan),
        .rsp_overflow   (rsp_overflow),
`ifdef ALU_ARB_OPCHK_EN
        .rsp_error      (rsp_error),
`endif
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        req_opcode[5*i +: 5]    = op;
        req_operandA[32*i +: 32] = a;
        req_operandB[32*i +: 32] = b;
        req_shiftamt[5*i +: 5]  = sh;
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 2'b11;
        req_opcode   = '0;
        req_operandA = '0;
        req_operandB = '0;
        req_shiftamt = '0;
        rsp_ready    = 1'b1;

        // Reset state: requests pending but nothing granted while in reset.
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_result", 64'(rsp_result), 64'h0);
        chk("rst_flags", 64'({rsp_isNotEqual, rsp_isLessThan, rsp_overflow}), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
`ifdef ALU_ARB_OPCHK_EN
        chk("rst_error", 64'(rsp_error), 64'h0);
`endif

        // Reset during EXEC discards the op.
        reset     = 1'b1;
        req_valid = 2'b01;
        set_req(0, 5'd0, 32'd5, 32'd7, 5'd0);
        #1 chk("mid_ready", 64'(req_ready), 64'h1);
        @(negedge clock);
        req_valid = 2'b00;
        chk("mid_exec_busy", 64'(busy), 64'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("mid_no_rsp", 64'(rsp_valid), 64'h0);
            chk("mid_no_busy", 64'(busy), 64'h0);
        end

        // Single add with signed overflow.
        req_valid = 2'b01;
        set_req(0, 5'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        #1 chk("ovf_ready", 64'(req_ready), 64'h1);
        @(negedge clock);
        req_valid = 2'b00;
        chk("ovf_exec_valid", 64'(rsp_valid), 64'h0);
        chk("ovf_exec_busy", 64'(busy), 64'h1);
        @(negedge clock);
        chk("ovf_valid", 64'(rsp_valid), 64'h1);
        chk("ovf_result", 64'(rsp_result), 64'h8000_0000);
        chk("ovf_flag", 64'(rsp_overflow), 64'h1);
        chk("ovf_id", 64'(rsp_id), 64'h0);
        chk("ovf_lt", 64'(rsp_isLessThan), 64'h0);
        chk("ovf_ne", 64'(rsp_isNotEqual), 64'h1);
        @(negedge clock);
        chk("ovf_done_valid", 64'(rsp_valid), 64'h0);
        chk("ovf_done_busy", 64'(busy), 64'h0);

        // Backpressure: req0 AND held in RESP for 10 cycles while req1 waits.
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, 5'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        #1 chk("bp_ready0", 64'(req_ready), 64'h1);
        @(negedge clock);
        req_valid = 2'b10;
        set_req(1, 5'd4, 32'h1, 32'h0, 5'd31);
        chk("bp_exec_ready", 64'(req_ready), 64'h0);
        @(negedge clock);
        chk("bp_valid", 64'(rsp_valid), 64'h1);
        chk("bp_result", 64'(rsp_result), 64'h0000_F000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_hold_valid", 64'(rsp_valid), 64'h1);
            chk("bp_hold_result", 64'(rsp_result), 64'h0000_F000);
            chk("bp_hold_id", 64'(rsp_id), 64'h0);
            chk("bp_hold_busy", 64'(busy), 64'h1);
            chk("bp_hold_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_rel_busy", 64'(busy), 64'h0);
        chk("bp_rel_valid", 64'(rsp_valid), 64'h0);
        chk("bp_rel_ready", 64'(req_ready), 64'h2);
        @(negedge clock);
        req_valid = 2'b00;
        @(negedge clock);
        chk("sll_id", 64'(rsp_id), 64'h1);
        chk("sll_result", 64'(rsp_result), 64'h8000_0000);
        chk("sll_lt", 64'(rsp_isLessThan), 64'h0);
        chk("sll_ovf", 64'(rsp_overflow), 64'h0);
        @(negedge clock);

        // Both requesters valid continuously: grants alternate starting at 0.
        req_valid = 2'b11;
        set_req(0, 5'd1, 32'd3, 32'd5, 5'd0);
        set_req(1, 5'd5, 32'h8000_0000, 32'h0, 5'd4);
        for (int g = 0; g < 4; g++) begin
            #1 chk("rr_grant", 64'(req_ready), (g % 2 == 0) ? 64'h1 : 64'h2);
            @(negedge clock);
            chk("rr_exec_ready", 64'(req_ready), 64'h0);
            @(negedge clock);
            chk("rr_id", 64'(rsp_id), 64'(g % 2));
            chk("rr_result", 64'(rsp_result), (g % 2 == 0) ? 64'hFFFF_FFFE : 64'hF800_0000);
            chk("rr_lt", 64'(rsp_isLessThan), 64'h1);
            chk("rr_ovf", 64'(rsp_overflow), 64'h0);
            @(negedge clock);
        end
        req_valid = 2'b00;

        // Opcode 9 with A=2, B=3.
        req_valid = 2'b01;
        set_req(0, 5'd9, 32'd2, 32'd3, 5'd0);
        #1 chk("op9_ready", 64'(req_ready), 64'h1);
        @(negedge clock);
        req_valid = 2'b00;
        @(negedge clock);
        chk("op9_valid", 64'(rsp_valid), 64'h1);
`ifdef ALU_ARB_OPCHK_EN
        chk("op9_error", 64'(rsp_error), 64'h1);
        chk("op9_result", 64'(rsp_result), 64'h0);
        chk("op9_flags", 64'({rsp_isNotEqual, rsp_isLessThan, rsp_overflow}), 64'h0);
`else
        chk("op9_result", 64'(rsp_result), 64'h5);
        chk("op9_flags", 64'({rsp_isNotEqual, rsp_isLessThan, rsp_overflow}), 64'h6);
`endif
        @(negedge clock);
        chk("op9_done", 64'(rsp_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
